perceptron_trainer: RTL
=======================

// Module: perceptron_trainer
// PURPOSE
//  Initiator side of the perceptron's training interface: stores a training set, replays it
//  epoch by epoch into a perceptron (x, train, learning_rate, expected_y), samples the returned
//  y, counts misclassifications per epoch, and stops on a zero-error epoch or MAX_EPOCHS.
//  Sits between host/config logic and one perceptron instance.
// PARAMETERS
//  N           8    perceptron width; feature vector is N-1 bits (bit 0 = bias, internal)
//  NUM_SAMPLES 16   training-set depth (power of two, >=2); ADDR_W = clog2(NUM_SAMPLES)
//  LATENCY     4    perceptron training pipeline depth M (train pulse -> weight update)
//  MAX_EPOCHS  255  epoch limit, must fit in 8 bits
// PORTS
//  clk            in   1       clock, all logic on rising edge
//  rst            in   1       asynchronous, active-high reset
//  load_en        in   1       write one training sample (ignored while busy)
//  load_addr      in   ADDR_W  sample slot
//  load_x         in   N-1     sample feature vector
//  load_y         in   32      sample expected output (signed fixed point)
//  num_samples    in   ADDR_W+1 samples used per epoch, 1..NUM_SAMPLES (0 treated as 1)
//  learning_rate  in   32      passed through, captured on start
//  tolerance      in   32      unsigned; error when |y - expected| > tolerance, captured on start
//  start          in   1       one-cycle pulse, begins training (ignored while busy)
//  abort          in   1       stop at next sample boundary
//  p_x            out  N-1     to perceptron x
//  p_train        out  1       to perceptron train
//  p_learning_rate out 32      to perceptron learning_rate
//  p_expected_y   out  32      to perceptron expected_y
//  p_y            in   32      from perceptron y (signed)
//  busy           out  1       high from cycle after start until done
//  done           out  1       one-cycle pulse at end of training
//  converged      out  1       sticky until next start: last epoch had zero errors
//  epoch_count    out  8       epochs completed
//  epoch_errors   out  ADDR_W+1 error count of last completed epoch
// BEHAVIOUR
//  Reset: all outputs 0, FSM IDLE, counters 0. RAM contents not reset.
//  FSM: IDLE -> PRESENT -> WAIT -> CHECK -> SETTLE -> (PRESENT | EPOCH_END) ; EPOCH_END ->
//   PRESENT | FINISH ; FINISH -> IDLE.
//  IDLE: start captures learning_rate, tolerance, num_samples; clears counters, converged.
//  Sample slot, LATENCY+1 cycles, sample index k, slot start cycle t:
//   t: PRESENT, p_x/p_expected_y = RAM[k] (registered read), p_train=1 for this cycle only.
//   t+1..t+LATENCY-2: WAIT, p_train=0, p_x/p_expected_y held.
//   t+LATENCY-1: CHECK, p_y captured (same cycle perceptron consumes delayed train);
//    diff = 33-bit signed p_y - p_expected_y; error if |diff| > tolerance; err_cnt++ on error.
//   t+LATENCY: SETTLE, p_x held for weight write; k++ or epoch end when k == num_samples-1.
//  EPOCH_END (1 cycle): epoch_errors <= err_cnt, epoch_count++, err_cnt <= 0, k <= 0;
//   if err_cnt==0 -> converged=1, FINISH; else if epoch_count+1 == MAX_EPOCHS -> FINISH;
//   else PRESENT.
//  FINISH: done=1 one cycle, busy=0 next cycle, p_train=0; p_x/p_expected_y hold last values.
//  abort: latched; honoured at SETTLE (never cuts a train pulse): partial epoch not counted,
//   epoch_errors unchanged, converged=0, -> FINISH.
//  start and abort in same IDLE cycle: start wins, abort ignored.
//  load_en during busy ignored; load_en and start same IDLE cycle: write completes, start taken.
//  Reset mid-slot: p_train drops immediately (async), perceptron weights are not our concern.
//  Counters saturate: err_cnt cannot exceed num_samples; epoch_count stops at MAX_EPOCHS.
// STRUCTURE
//  perceptron_pkg (shared include): FSM state encoding, LATENCY default, data width 32,
//   abs-diff helper function.
//  Sub-module training_set_ram: NUM_SAMPLES x (N-1+32) sync-write, registered-read RAM.
//  FSM, slot counter, sample/err/epoch counters in top.
// TESTING
//  Reset: assert rst mid-WAIT -> p_train, busy, done, counters 0 same cycle; idle after release.
//  Slot timing: 1 sample, LATENCY=4, stub p_y=expected -> p_train high exactly 1 of every 5
//   cycles, p_y sampled at t+3, converged=1, epoch_count=1, done pulse once.
//  Error count: 4 samples, stub returns expected+10 for samples 1,3, tolerance=5 -> epoch_errors=2
//   each epoch; tolerance=10 -> 0 errors, converged after epoch 1.
//  Non-convergence: MAX_EPOCHS=3, stub always wrong -> epoch_count=3, converged=0, done.
//  Real perceptron AND-gate set (4 samples, lr=1/8) -> converges, epoch_errors=0, x held per slot.
//  Abort during sample 2 of epoch 2 -> finish at that SETTLE, epoch_count=1, start/load ignored
//   while busy, negative diff (p_y=-20, exp=0, tol=15) counted as error.

Source files
------------

// File: rtl/perceptron_pkg.sv
// perceptron_pkg: shared FSM encoding, data width, default training latency and the
// error-magnitude helper used by the trainer.
package perceptron_pkg;

    localparam int DATA_W      = 32;
    localparam int LATENCY_DEF = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRESENT,
        S_WAIT,
        S_CHECK,
        S_SETTLE,
        S_EPOCH_END,
        S_FINISH
    } state_e;

    // |a - b| over signed operands; one extra bit keeps the full range exact
    function automatic logic [DATA_W:0] abs_diff(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
        logic signed [DATA_W:0] d;
        d = $signed({a[DATA_W-1], a}) - $signed({b[DATA_W-1], b});
        return d[DATA_W] ? -d : d;
    endfunction

endpackage

// File: rtl/training_set_ram.sv
// training_set_ram: sample store with synchronous write and an enabled, registered read.
// A same-cycle write to the read address is forwarded so the new sample is read.
module training_set_ram #(
    parameter int DEPTH  = 16,
    parameter int WIDTH  = 39,
    parameter int ADDR_W = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [WIDTH-1:0]  wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [WIDTH-1:0]  rdata_o
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) mem[waddr_i] <= wdata_i;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)     rdata_o <= '0;
        else if (re_i) rdata_o <= (we_i && waddr_i == raddr_i) ? wdata_i : mem[raddr_i];
    end

endmodule

// File: rtl/perceptron_trainer.sv
// perceptron_trainer: replays a stored training set into a perceptron epoch by epoch,
// counts misclassified samples and stops on an error-free epoch, the epoch limit or abort.
module perceptron_trainer
    import perceptron_pkg::*;
#(
    parameter int  N           = 8,
    parameter int  NUM_SAMPLES = 16,
    parameter int  LATENCY     = LATENCY_DEF,
    parameter int  MAX_EPOCHS  = 255,
    localparam int ADDR_W      = $clog2(NUM_SAMPLES)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [N-2:0]      load_x,
    input  logic [31:0]       load_y,
    input  logic [ADDR_W:0]   num_samples,
    input  logic [31:0]       learning_rate,
    input  logic [31:0]       tolerance,
    input  logic              start,
    input  logic              abort,
    output logic [N-2:0]      p_x,
    output logic              p_train,
    output logic [31:0]       p_learning_rate,
    output logic [31:0]       p_expected_y,
    input  logic [31:0]       p_y,
    output logic              busy,
    output logic              done,
    output logic              converged,
    output logic [7:0]        epoch_count,
    output logic [ADDR_W:0]   epoch_errors
);

    localparam int RAM_W = N - 1 + DATA_W;

    state_e              state_q, state_d;
    logic [7:0]          wait_q, wait_d;
    logic [ADDR_W-1:0]   k_q, k_d;
    logic [ADDR_W:0]     err_q, err_d, ns_q, ns_d, ep_err_q, ep_err_d;
    logic [7:0]          ep_cnt_q, ep_cnt_d;
    logic [31:0]         lr_q, lr_d, tol_q, tol_d;
    logic                abort_q, abort_d, conv_q, conv_d;
    logic                rd_en, last_sample;
    logic [ADDR_W-1:0]   rd_addr;
    logic [RAM_W-1:0]    rd_data;

    training_set_ram #(
        .DEPTH (NUM_SAMPLES),
        .WIDTH (RAM_W),
        .ADDR_W(ADDR_W)
    ) u_ram (
        .clk_i  (clk),
        .rst_i  (rst),
        .we_i   (load_en && state_q == S_IDLE),
        .waddr_i(load_addr),
        .wdata_i({load_x, load_y}),
        .re_i   (rd_en),
        .raddr_i(rd_addr),
        .rdata_o(rd_data)
    );

    assign last_sample = {1'b0, k_q} == ns_q - 1'b1;

    always_comb begin
        state_d  = state_q;
        wait_d   = wait_q;
        k_d      = k_q;
        err_d    = err_q;
        ns_d     = ns_q;
        ep_err_d = ep_err_q;
        ep_cnt_d = ep_cnt_q;
        lr_d     = lr_q;
        tol_d    = tol_q;
        conv_d   = conv_q;
        abort_d  = (state_q != S_IDLE) ? (abort_q | abort) : abort_q;
        rd_en    = 1'b1;
        rd_addr  = k_q;
        case (state_q)
            S_IDLE: begin
                rd_en   = start;
                rd_addr = '0;
                if (start) begin
                    state_d  = S_PRESENT;
                    lr_d     = learning_rate;
                    tol_d    = tolerance;
                    ns_d     = (num_samples == '0) ? (ADDR_W+1)'(1) :
                               (num_samples > (ADDR_W+1)'(NUM_SAMPLES)) ? (ADDR_W+1)'(NUM_SAMPLES) :
                               num_samples;
                    k_d      = '0;
                    err_d    = '0;
                    ep_err_d = '0;
                    ep_cnt_d = '0;
                    conv_d   = 1'b0;
                    abort_d  = 1'b0;
                end
            end
            S_PRESENT: begin
                wait_d  = '0;
                state_d = (LATENCY > 2) ? S_WAIT : S_CHECK;
            end
            S_WAIT: begin
                wait_d = wait_q + 8'd1;
                if (wait_q == 8'(LATENCY - 3)) state_d = S_CHECK;
            end
            S_CHECK: begin
                state_d = S_SETTLE;
                if (abs_diff(p_y, p_expected_y) > {1'b0, tol_q} && err_q < ns_q) err_d = err_q + 1'b1;
            end
            S_SETTLE: begin
                // the read address runs one cycle ahead so the next PRESENT sees its sample
                if (abort_q || abort) begin
                    state_d = S_FINISH;
                    conv_d  = 1'b0;
                end else if (last_sample) begin
                    state_d = S_EPOCH_END;
                end else begin
                    state_d = S_PRESENT;
                    k_d     = k_q + 1'b1;
                    rd_addr = k_q + 1'b1;
                end
            end
            S_EPOCH_END: begin
                ep_err_d = err_q;
                ep_cnt_d = (ep_cnt_q < 8'(MAX_EPOCHS)) ? ep_cnt_q + 8'd1 : ep_cnt_q;
                err_d    = '0;
                k_d      = '0;
                if (err_q == '0) begin
                    conv_d  = 1'b1;
                    state_d = S_FINISH;
                end else if ({1'b0, ep_cnt_q} + 9'd1 >= 9'(MAX_EPOCHS)) begin
                    state_d = S_FINISH;
                end else begin
                    state_d = S_PRESENT;
                    rd_addr = '0;
                end
            end
            S_FINISH: begin
                rd_en   = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            wait_q   <= '0;
            k_q      <= '0;
            err_q    <= '0;
            ns_q     <= '0;
            ep_err_q <= '0;
            ep_cnt_q <= '0;
            lr_q     <= '0;
            tol_q    <= '0;
            conv_q   <= 1'b0;
            abort_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            wait_q   <= wait_d;
            k_q      <= k_d;
            err_q    <= err_d;
            ns_q     <= ns_d;
            ep_err_q <= ep_err_d;
            ep_cnt_q <= ep_cnt_d;
            lr_q     <= lr_d;
            tol_q    <= tol_d;
            conv_q   <= conv_d;
            abort_q  <= abort_d;
        end
    end

    assign p_x             = rd_data[DATA_W +: N-1];
    assign p_expected_y    = rd_data[DATA_W-1:0];
    assign p_train         = state_q == S_PRESENT;
    assign p_learning_rate = lr_q;
    assign busy            = state_q != S_IDLE;
    assign done            = state_q == S_FINISH;
    assign converged       = conv_q;
    assign epoch_count     = ep_cnt_q;
    assign epoch_errors    = ep_err_q;

endmodule
